dram_write_arbiter: RTL and testbench
=====================================

DRAM_WRITE_ARBITER -- requirements
Module: dram_write_arbiter

Interface
REQ-001 Parameter NUM_CH, 8, number of reorder-buffer channels (2..16).
REQ-002 Parameter DATA_W, 256, DRAM data width.
REQ-003 Parameter ADDR_W, 25, DRAM word address width.
REQ-004 Parameter BURST_LEN, 16, beats per DRAM burst (1..31).
REQ-005 Parameter ADDR_BASE, 0, first burst address of circular region.
REQ-006 Parameter ADDR_LIMIT, 2^ADDR_W-BURST_LEN, last legal burst start address.
REQ-007 Clock clk; reset rst_n, synchronous, active-low.
REQ-008 enable  in  1  run; deassert returns FSM to IDLE after current burst.
REQ-009 ch_ready  in  NUM_CH  per-channel "one full burst available" flag.
REQ-010 ch_rd_req  out  NUM_CH  one-hot read strobe to granted channel.
REQ-011 ch_sel  out  clog2(NUM_CH)  granted channel index (external data mux select).
REQ-012 ch_rd_data  in  DATA_W  muxed channel data, valid exactly 1 cycle after ch_rd_req.
REQ-013 trigger  in  1  single-cycle trigger pulse.
REQ-014 post_trig_bursts  in  16  bursts to write after trigger, sampled on trigger.
REQ-015 dram_wait_req  in  1  DRAM stall; beat accepted when dram_write=1 and dram_wait_req=0.
REQ-016 dram_write, dram_burst_begin  out  1 each  write strobe, first-beat marker.
REQ-017 dram_burst_count  out  5  equals BURST_LEN while dram_write=1, else 0.
REQ-018 dram_addr  out  ADDR_W  burst start address, constant for whole burst.
REQ-019 dram_wdata  out  DATA_W  head of internal beat FIFO.
REQ-020 trig_addr  out  ADDR_W  burst address captured at trigger; done  out  1  capture complete.

Function
REQ-021 FSM states IDLE, ARB, BURST, STOPPED; IDLE->ARB when enable=1 and done=0.
REQ-022 ARB: round-robin grant, search starts at (last_grant+1) mod NUM_CH; first channel with ch_ready=1 granted next cycle, FSM->BURST; none ready -> stay ARB.
REQ-023 ch_sel registered at grant, held constant through BURST.
REQ-024 Internal 2-entry beat FIFO; ch_rd_req asserted in cycle t iff in BURST, beats requested < BURST_LEN, and fifo_count + in_flight < 2; data written to FIFO at t+1.
REQ-025 dram_write = 1 whenever BURST and FIFO non-empty; dram_wdata/dram_write held stable while dram_wait_req=1.
REQ-026 dram_burst_begin = 1 only with the first beat of a burst, held until that beat is accepted.
REQ-027 Back-to-back throughput: with dram_wait_req=0, one beat accepted per cycle after 2-cycle first-beat latency from grant.
REQ-028 After last beat accepted: dram_addr += BURST_LEN; if old value = ADDR_LIMIT, next = ADDR_BASE (wrap); FSM->ARB, or IDLE if enable=0.
REQ-029 trigger in IDLE/ARB/BURST with trig_armed=0: trig_addr <= current dram_addr, counter <= post_trig_bursts, trig_armed <= 1; trigger while armed or STOPPED ignored.
REQ-030 Armed: counter decrements on each burst completion; burst completing with counter=1, or counter=0 at arm time with burst completion/ARB entry, -> STOPPED.
REQ-031 STOPPED: done=1, no ch_rd_req, no dram_write; exit to IDLE (done=0, trig_armed=0) only when enable=0.
REQ-032 trigger coincident with last-beat acceptance captures the pre-increment address.
REQ-033 ch_ready dropping mid-burst does not abort burst (flag means whole burst buffered).

Reset
REQ-034 rst_n=0 at clock edge: FSM=IDLE, FIFO and in-flight cleared, last_grant=NUM_CH-1, dram_addr=ADDR_BASE, all outputs 0, trig_armed=0; mid-burst reset abandons burst without further beats.

Verification
REQ-035 All 8 ready, wait_req=0, BURST_LEN=16: grants 0,1,..,7,0; 16 consecutive dram_write beats per burst, addresses 0,16,32,...
REQ-036 dram_wait_req toggled every other cycle: no beat lost or duplicated; data sequence 1..16 intact; burst_begin only on beat 1.
REQ-037 ADDR_LIMIT=48: bursts at 0,16,32,48 then wrap to 0.
REQ-038 trigger during burst at addr 32, post_trig_bursts=3: trig_addr=32; STOPPED after 3 further completed bursts; done=1 until enable=0.
REQ-039 Only channel 5 ready then channel 2: grant 5 then 2; ch_rd_req one-hot, never >BURST_LEN pulses per burst.
REQ-040 rst_n low at beat 7 of burst: next cycle all outputs 0, dram_addr=ADDR_BASE, restart grants channel 0.

Source files
------------

// File: rtl/dram_write_arbiter.sv
// rtl/dram_write_arbiter.sv - round-robin channel arbiter feeding DRAM write bursts with trigger capture
module dram_write_arbiter #(
    parameter int NUM_CH     = 8,
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 25,
    parameter int BURST_LEN  = 16,
    parameter int ADDR_BASE  = 0,
    parameter int ADDR_LIMIT = 2**ADDR_W - BURST_LEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [NUM_CH-1:0]         ch_ready_i,
    output logic [NUM_CH-1:0]         ch_rd_req_o,
    output logic [$clog2(NUM_CH)-1:0] ch_sel_o,
    input  logic [DATA_W-1:0]         ch_rd_data_i,
    input  logic                      trigger_i,
    input  logic [15:0]               post_trig_bursts_i,
    input  logic                      dram_wait_req_i,
    output logic                      dram_write_o,
    output logic                      dram_burst_begin_o,
    output logic [4:0]                dram_burst_count_o,
    output logic [ADDR_W-1:0]         dram_addr_o,
    output logic [DATA_W-1:0]         dram_wdata_o,
    output logic [ADDR_W-1:0]         trig_addr_o,
    output logic                      done_o
);
    localparam int                SEL_W   = $clog2(NUM_CH);
    localparam logic [4:0]        BL      = 5'(BURST_LEN);
    localparam logic [ADDR_W-1:0] A_BASE  = ADDR_W'(ADDR_BASE);
    localparam logic [ADDR_W-1:0] A_LIMIT = ADDR_W'(ADDR_LIMIT);
    localparam logic [ADDR_W-1:0] A_STEP  = ADDR_W'(BURST_LEN);
    localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, ARB, BURST, STOPPED} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    last_grant_q, ch_sel_q;
    logic [SEL_W-1:0]    grant_idx, cand;
    logic                grant_found, grant_take;
    logic [4:0]          req_cnt_q, acc_cnt_q;
    logic                inflight_q;
    logic [DATA_W-1:0]   fifo_mem_q [2];
    logic                fifo_wr_q, fifo_rd_q;
    logic [1:0]          fifo_cnt_q;
    logic [2:0]          slots_used;
    logic                in_burst, dram_write, accept, last_accept, rd_req;
    logic [ADDR_W-1:0]   dram_addr_q, trig_addr_q;
    logic                trig_armed_q, trig_fire, stop_burst, stop_arb;
    logic [15:0]         trig_cnt_q;

    assign in_burst    = (state_q == BURST);
    assign dram_write  = in_burst && (fifo_cnt_q != 2'd0);
    assign accept      = dram_write && !dram_wait_req_i;
    assign last_accept = accept && (acc_cnt_q == BL - 5'd1);
    // A slot emptied by a beat leaving this cycle is free for a new read, giving one beat per cycle.
    assign slots_used  = {1'b0, fifo_cnt_q} + {2'b0, inflight_q} - {2'b0, accept};
    assign rd_req      = in_burst && (req_cnt_q < BL) && (slots_used < 3'd2);

    assign trig_fire  = trigger_i && !trig_armed_q && (state_q != STOPPED);
    assign stop_burst = trig_armed_q && (trig_cnt_q <= 16'd1);
    assign stop_arb   = trig_armed_q && (trig_cnt_q == 16'd0);
    assign grant_take = (state_q == ARB) && (state_d == BURST);

    assign ch_rd_req_o        = rd_req ? (NUM_CH'(1) << ch_sel_q) : '0;
    assign ch_sel_o           = ch_sel_q;
    assign dram_write_o       = dram_write;
    assign dram_burst_begin_o = dram_write && (acc_cnt_q == 5'd0);
    assign dram_burst_count_o = dram_write ? BL : 5'd0;
    assign dram_addr_o        = dram_addr_q;
    assign dram_wdata_o       = fifo_mem_q[fifo_rd_q];
    assign trig_addr_o        = trig_addr_q;
    assign done_o             = (state_q == STOPPED);

    // round-robin search starting just after the last granted channel
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = SEL_W'((int'(last_grant_q) + i) % NUM_CH);
            if (!grant_found && ch_ready_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) state_d = ARB;
            end
            ARB: begin
                if (stop_arb)         state_d = STOPPED;
                else if (!enable_i)   state_d = IDLE;
                else if (grant_found) state_d = BURST;
            end
            BURST: begin
                if (last_accept) begin
                    if (stop_burst)     state_d = STOPPED;
                    else if (!enable_i) state_d = IDLE;
                    else                state_d = ARB;
                end
            end
            STOPPED: begin
                if (!enable_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // grant capture and per-burst request/accept beat counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= LAST_CH;
            ch_sel_q     <= '0;
            req_cnt_q    <= '0;
            acc_cnt_q    <= '0;
            inflight_q   <= 1'b0;
        end else begin
            inflight_q <= rd_req;
            if (grant_take) begin
                last_grant_q <= grant_idx;
                ch_sel_q     <= grant_idx;
                req_cnt_q    <= '0;
                acc_cnt_q    <= '0;
            end else begin
                req_cnt_q <= req_cnt_q + {4'b0, rd_req};
                acc_cnt_q <= acc_cnt_q + {4'b0, accept};
            end
        end
    end

    // two-entry beat FIFO: push returning channel data, pop on DRAM acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_wr_q     <= 1'b0;
            fifo_rd_q     <= 1'b0;
            fifo_cnt_q    <= '0;
        end else begin
            if (inflight_q) begin
                fifo_mem_q[fifo_wr_q] <= ch_rd_data_i;
                fifo_wr_q             <= ~fifo_wr_q;
            end
            if (accept) fifo_rd_q <= ~fifo_rd_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, accept};
        end
    end

    // circular burst address advances when the last beat leaves
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dram_addr_q <= A_BASE;
        end else if (last_accept) begin
            dram_addr_q <= (dram_addr_q == A_LIMIT) ? A_BASE : dram_addr_q + A_STEP;
        end
    end

    // trigger capture: the address seen here is the pre-increment one even on the last beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_addr_q  <= '0;
            trig_cnt_q   <= '0;
            trig_armed_q <= 1'b0;
        end else if (trig_fire) begin
            trig_addr_q  <= dram_addr_q;
            trig_cnt_q   <= post_trig_bursts_i;
            trig_armed_q <= 1'b1;
        end else if (state_q == STOPPED && !enable_i) begin
            trig_armed_q <= 1'b0;
        end else if (trig_armed_q && last_accept && trig_cnt_q != 16'd0) begin
            trig_cnt_q <= trig_cnt_q - 16'd1;
        end
    end
endmodule

// File: tb/tb_dram_write_arbiter.sv
// tb/tb_dram_write_arbiter.sv - scoreboard bench for dram_write_arbiter
module tb_dram_write_arbiter;
    localparam int NCH   = 8;
    localparam int DW    = 32;
    localparam int AW    = 25;
    localparam int BL    = 16;
    localparam int LIMIT = 48;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic [NCH-1:0] ch_ready;
    logic [NCH-1:0] ch_rd_req;
    logic [2:0]     ch_sel;
    logic [DW-1:0]  ch_rd_data;
    logic           trigger;
    logic [15:0]    post_trig;
    logic           dram_wait_req;
    logic           dram_write;
    logic           dram_burst_begin;
    logic [4:0]     dram_burst_count;
    logic [AW-1:0]  dram_addr;
    logic [DW-1:0]  dram_wdata;
    logic [AW-1:0]  trig_addr;
    logic           done;

    dram_write_arbiter #(
        .NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL),
        .ADDR_BASE(0), .ADDR_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .ch_ready_i(ch_ready),
        .ch_rd_req_o(ch_rd_req), .ch_sel_o(ch_sel), .ch_rd_data_i(ch_rd_data),
        .trigger_i(trigger), .post_trig_bursts_i(post_trig),
        .dram_wait_req_i(dram_wait_req), .dram_write_o(dram_write),
        .dram_burst_begin_o(dram_burst_begin), .dram_burst_count_o(dram_burst_count),
        .dram_addr_o(dram_addr), .dram_wdata_o(dram_wdata),
        .trig_addr_o(trig_addr), .done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        int            beat;
        int            ch;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   beats_acc = 0;
    int   first_cyc = 0;
    int   wait_mode = 0;
    bit   nostall = 1'b0;

    // channel world: bursts buffered and reads served per channel
    int pending [NCH];
    int rdcnt   [NCH];
    // reference model: bursts still to be granted, bursts granted, grant pointer, address
    int model_pend   [NCH];
    int model_bursts [NCH];
    int model_last;
    int model_addr;
    int pushed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void refresh_ready();
        for (int k = 0; k < NCH; k++) ch_ready[k] = (pending[k] > 0);
    endfunction

    task automatic give(input int k, input int n);
        pending[k]    += n;
        model_pend[k] += n;
    endtask

    task automatic clear_models();
        exp_q.delete();
        for (int k = 0; k < NCH; k++) begin
            pending[k] = 0; rdcnt[k] = 0; model_pend[k] = 0; model_bursts[k] = 0;
        end
        model_last = NCH - 1;
        model_addr = 0;
        pushed     = 0;
        refresh_ready();
    endtask

    // expected bursts: round-robin over buffered bursts, addresses step and wrap
    task automatic model_run(input int limit);
        int n;
        int k;
        int c;
        n = 0;
        while (n < limit) begin
            k = -1;
            for (int i = 1; i <= NCH; i++) begin
                c = (model_last + i) % NCH;
                if (k < 0 && model_pend[c] > 0) k = c;
            end
            if (k < 0) break;
            for (int b = 0; b < BL; b++) begin
                exp_t e;
                e.data = DW'((k << 24) | (model_bursts[k] * BL + b));
                e.addr = AW'(model_addr);
                e.beat = b;
                e.ch   = k;
                exp_q.push_back(e);
            end
            model_pend[k]--;
            model_bursts[k]++;
            model_last = k;
            model_addr = (model_addr == LIMIT) ? 0 : model_addr + BL;
            pushed++;
            n++;
        end
    endtask

    task automatic check_zero();
        check("rst_write", dram_write, 0);
        check("rst_begin", dram_burst_begin, 0);
        check("rst_count", dram_burst_count, 0);
        check("rst_addr", dram_addr, 0);
        check("rst_rd_req", ch_rd_req, 0);
        check("rst_sel", ch_sel, 0);
        check("rst_done", done, 0);
        check("rst_wdata", dram_wdata, 0);
        check("rst_trig_addr", trig_addr, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        clear_models();
        @(negedge clk);
        check_zero();
        rst_n = 1'b1;
    endtask

    task automatic check_reads();
        int s;
        s = 0;
        for (int k = 0; k < NCH; k++) s += rdcnt[k];
        check("channel_reads", s, pushed * BL);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        check_reads();
    endtask

    task automatic wait_burst_at(input int addr);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dram_burst_begin && dram_addr == AW'(addr)) && n < 3000);
        check("burst_seen", (dram_burst_begin && dram_addr == AW'(addr)), 1);
    endtask

    task automatic pulse_trigger(input int post);
        trigger   = 1'b1;
        post_trig = 16'(post);
        @(negedge clk);
        trigger   = 1'b0;
        post_trig = 16'hFFFF;
    endtask

    // channel responder: data appears the cycle after a read strobe
    initial begin : responder
        logic [NCH-1:0] req_s;
        ch_rd_data = '0;
        forever begin
            @(negedge clk);
            req_s = ch_rd_req;
            @(posedge clk); #1;
            ch_rd_data = $urandom();
            for (int k = 0; k < NCH; k++) begin
                if (req_s[k]) begin
                    ch_rd_data = DW'((k << 24) | rdcnt[k]);
                    if ((rdcnt[k] % BL) == 0 && pending[k] > 0) begin
                        pending[k]--;
                        refresh_ready();
                    end
                    rdcnt[k]++;
                end
            end
        end
    end

    // DRAM stall generator
    initial begin : staller
        dram_wait_req = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (wait_mode)
                1:       dram_wait_req = ~dram_wait_req;
                2:       dram_wait_req = 1'($urandom_range(0, 1));
                default: dram_wait_req = 1'b0;
            endcase
        end
    end

    // monitor: pop expected beats on every accepted DRAM beat
    initial begin : monitor
        bit            prev_stall;
        logic [DW-1:0] prev_wdata;
        logic [AW-1:0] prev_addr;
        logic          prev_begin;
        exp_t          e;
        prev_stall = 1'b0;
        prev_wdata = '0;
        prev_addr  = '0;
        prev_begin = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (prev_stall) begin
                    check("stall_write", dram_write, 1);
                    check("stall_wdata", dram_wdata, prev_wdata);
                    check("stall_addr", dram_addr, prev_addr);
                    check("stall_begin", dram_burst_begin, prev_begin);
                end
                if (ch_rd_req != '0) check("rd_req_onehot", $onehot(ch_rd_req), 1);
                if (dram_write && !dram_wait_req) begin
                    beats_acc++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h required=none", dram_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", dram_wdata, e.data);
                        check("beat_addr", dram_addr, e.addr);
                        check("beat_begin", dram_burst_begin, (e.beat == 0));
                        check("beat_count", dram_burst_count, BL);
                        check("beat_sel", ch_sel, e.ch);
                        if (e.beat == 0) first_cyc = cyc;
                        if (nostall && e.beat == BL - 1) check("burst_span", cyc - first_cyc, BL - 1);
                    end
                end
                prev_stall = dram_write && dram_wait_req;
                prev_wdata = dram_wdata;
                prev_addr  = dram_addr;
                prev_begin = dram_burst_begin;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int n;
        rst_n     = 1'b0;
        enable    = 1'b0;
        trigger   = 1'b0;
        post_trig = 16'hFFFF;
        clear_models();
        do_reset();
        enable = 1'b1;

        // all channels ready, no stall: grants 0..7 then 0, back-to-back beats
        @(negedge clk);
        nostall = 1'b1;
        for (int k = 0; k < NCH; k++) give(k, 1);
        give(0, 1);
        refresh_ready();
        model_run(100);
        drain();
        nostall = 1'b0;

        // alternating stall, then random stalls with random buffered bursts
        for (int ph = 0; ph < 3; ph++) begin
            wait_mode = (ph == 0) ? 1 : 2;
            @(negedge clk);
            for (int k = 0; k < NCH; k++) give(k, $urandom_range(0, 2));
            refresh_ready();
            model_run(100);
            drain();
        end

        // only channel 5, then only channel 2
        @(negedge clk);
        give(5, 1); refresh_ready(); model_run(100); drain();
        @(negedge clk);
        give(2, 1); refresh_ready(); model_run(100); drain();

        // trigger during the burst at address 32 with 3 post-trigger bursts
        wait_mode = 0;
        do_reset();
        @(negedge clk);
        for (int k = 0; k < NCH; k++) give(k, 1);
        refresh_ready();
        model_run(5);
        wait_burst_at(32);
        pulse_trigger(3);
        wait_burst_at(48);
        pulse_trigger(1);
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("trig_done", done, 1);
        check("trig_addr", trig_addr, 32);
        check("trig_bursts", exp_q.size(), 0);
        repeat (20) begin
            @(negedge clk);
            check("stopped_done", done, 1);
            check("stopped_rd_req", ch_rd_req, 0);
            check("stopped_write", dram_write, 0);
        end
        check_reads();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("exit_done", done, 0);
        enable = 1'b1;
        model_run(100);
        drain();

        // reset on the seventh beat of a burst
        @(negedge clk);
        for (int k = 0; k < NCH; k++) give(k, 1);
        refresh_ready();
        model_run(100);
        beats_acc = 0;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (beats_acc < 7 && n < 3000);
        check("beat7_seen", beats_acc, 7);
        rst_n = 1'b0;
        @(posedge clk); #2;
        clear_models();
        @(negedge clk);
        check_zero();
        @(negedge clk);
        check("rst_hold_write", dram_write, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NCH; k++) give(k, 1);
        refresh_ready();
        model_run(100);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
